// File: rtl/mips_datapath_memory_bus_master.sv
// mips_datapath_memory_bus_master: turns one pipeline memory-stage access
// (byte/half/word load or store) into a sequence of byte-bus transfers.
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   byteEnable_i[1:0]       access size: 0 None, 1 Byte, 2 Half, 3 Word
//   byteExtend_i            load extension: 0 Unsigned, 1 Signed
//   writeEnable_i           1 = store, 0 = load
//   req_i, addr_i, data_i   request, base byte address, store data
//   out_o                   registered, extended load result
//   stall_o                 pipeline hold
//   fault_o                 misalignment pulse (only with the macro below)
//   busValid_o, busWrite_o, busAddr_o, busWData_o   byte-bus request
//   busReady_i, busRData_i  byte-bus response
// Build option: define MIPS_DATAPATH_MEMORY_BUS_MASTER_ALIGN_CHECK_EN to
// reject misaligned half/word accesses without any bus cycles.
module mips_datapath_memory_bus_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        byteEnable_i,
    input  logic              byteExtend_i,
    input  logic              writeEnable_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       out_o,
    output logic              stall_o,
    output logic              fault_o,
    output logic              busValid_o,
    output logic              busWrite_o,
    output logic [ADDR_W-1:0] busAddr_o,
    output logic [7:0]        busWData_o,
    input  logic              busReady_i,
    input  logic [7:0]        busRData_i
);

    localparam logic [1:0] BE_NONE = 2'd0;
    localparam logic [1:0] BE_BYTE = 2'd1;
    localparam logic [1:0] BE_HALF = 2'd2;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        count_q;
    logic [1:0]        last_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              ext_q;
    logic [31:0]       lanes_q, lanes_d;
    logic [31:0]       out_q, out_d;

    logic       start;
    logic       misalign;
    logic       handshake;
    logic       last_beat;
    logic [1:0] last_idx;

    assign start = req_i & (byteEnable_i != BE_NONE);

    // Index of the final byte: 0 for Byte, 1 for Half, 3 for Word.
    always_comb begin
        last_idx = 2'd3;
        if (byteEnable_i == BE_BYTE) last_idx = 2'd0;
        if (byteEnable_i == BE_HALF) last_idx = 2'd1;
    end

`ifdef MIPS_DATAPATH_MEMORY_BUS_MASTER_ALIGN_CHECK_EN
    assign misalign = (last_idx == 2'd1 & addr_i[0])
                    | (last_idx == 2'd3 & addr_i[1:0] != 2'd0);
`else
    assign misalign = 1'b0;
`endif

    assign handshake = (state_q == XFER) & busReady_i;
    assign last_beat = handshake & (count_q == last_q);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = misalign ? DONE : XFER;
            XFER: if (last_beat) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall_o    = ((state_q == IDLE) & start) | (state_q == XFER);
        busValid_o = (state_q == XFER);
        busWrite_o = (state_q == XFER) & we_q;
        busAddr_o  = base_q + ADDR_W'(count_q);
        busWData_o = wdata_q[{count_q, 3'b000} +: 8];
    end

    // Lane merge of the byte arriving on this handshake
    always_comb begin
        lanes_d = lanes_q;
        if (handshake & ~we_q) lanes_d[{count_q, 3'b000} +: 8] = busRData_i;
    end

    // Extension uses the merged lanes so the last byte lands in out
    // on the same edge that enters DONE.
    always_comb begin
        unique case (last_q)
            2'd0:    out_d = {{24{ext_q & lanes_d[7]}}, lanes_d[7:0]};
            2'd1:    out_d = {{16{ext_q & lanes_d[15]}}, lanes_d[15:0]};
            default: out_d = lanes_d;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            last_q  <= 2'd0;
            base_q  <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            ext_q   <= 1'b0;
            lanes_q <= 32'd0;
            out_q   <= 32'd0;
        end else begin
            if ((state_q == IDLE) & start) begin
                count_q <= 2'd0;
                last_q  <= last_idx;
                base_q  <= addr_i;
                wdata_q <= data_i;
                we_q    <= writeEnable_i;
                ext_q   <= byteExtend_i;
            end
            if (handshake) begin
                count_q <= count_q + 2'd1;
                lanes_q <= lanes_d;
            end
            if (last_beat & ~we_q) out_q <= out_d;
        end
    end

    assign out_o = out_q;

`ifdef MIPS_DATAPATH_MEMORY_BUS_MASTER_ALIGN_CHECK_EN
    logic fault_q;

    // High only for the DONE cycle that follows a rejected request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) fault_q <= 1'b0;
        else       fault_q <= (state_q == IDLE) & start & misalign;
    end

    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_mips_datapath_memory_bus_master.sv
// tb_mips_datapath_memory_bus_master: directed vectors checked against a
// transaction-level model of the byte-bus master.
module tb_mips_datapath_memory_bus_master;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  byteEnable_i = 2'd0;
    logic        byteExtend_i = 1'b0;
    logic        writeEnable_i = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] out_o;
    logic        stall_o;
    logic        fault_o;
    logic        busValid_o;
    logic        busWrite_o;
    logic [31:0] busAddr_o;
    logic [7:0]  busWData_o;
    logic        busReady_i = 1'b1;
    logic [7:0]  busRData_i;

    always #5 clk = ~clk;

    mips_datapath_memory_bus_master #(.ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .byteEnable_i(byteEnable_i), .byteExtend_i(byteExtend_i),
        .writeEnable_i(writeEnable_i), .req_i(req_i),
        .addr_i(addr_i), .data_i(data_i),
        .out_o(out_o), .stall_o(stall_o), .fault_o(fault_o),
        .busValid_o(busValid_o), .busWrite_o(busWrite_o),
        .busAddr_o(busAddr_o), .busWData_o(busWData_o),
        .busReady_i(busReady_i), .busRData_i(busRData_i)
    );

    // Byte-addressed slave memory (low 8 address bits)
    logic [7:0] mem [0:255];
    assign busRData_i = mem[busAddr_o[7:0]];

    typedef struct packed {
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] obs_a[$];
    logic [7:0]  obs_d[$];
    int          checks = 0;
    int          errors = 0;
    int          beats_done = 0;
    int          hold_beat = -1;
    int          hold_left = 0;
    logic [31:0] out_model = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] be);
        if (be == 2'd1) return 1;
        if (be == 2'd2) return 2;
        if (be == 2'd3) return 4;
        return 0;
    endfunction

    function automatic bit misaligned(input logic [1:0] be,
                                      input logic [31:0] a);
`ifdef MIPS_DATAPATH_MEMORY_BUS_MASTER_ALIGN_CHECK_EN
        return (be == 2'd2 && a[0]) || (be == 2'd3 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Little-endian assembly from memory, then extension by arithmetic.
    function automatic logic [31:0] load_val(input logic [1:0] be,
                                             input logic sgn,
                                             input logic [31:0] a);
        int n = nbytes(be);
        logic [31:0] v = 32'd0;
        logic [31:0] mask;
        for (int k = 0; k < n; k++)
            v = v + (32'(mem[8'(a + 32'(k))]) << (8 * k));
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        if (sgn && v >= (32'd1 << (8 * n - 1))) v = v | ~mask;
        return v;
    endfunction

    // Per-cycle compare of bus beats, plus bus-ready stimulus.
    always @(negedge clk) begin
        if (!rst_i && stall_o) chk("out_stable", out_o, out_model);
        if (!rst_i && busValid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat got addr %h expected none",
                         busAddr_o);
            end else begin
                chk("bus_addr", busAddr_o, exp_q[0].a);
                chk("bus_write", {31'd0, busWrite_o}, {31'd0, exp_q[0].w});
                chk("bus_wdata", {24'd0, busWData_o}, {24'd0, exp_q[0].d});
            end
            if (beats_done == hold_beat && hold_left > 0) begin
                busReady_i = 1'b0;
                hold_left--;
            end else begin
                busReady_i = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                obs_a.push_back(busAddr_o);
                obs_d.push_back(busWData_o);
                beats_done++;
            end
        end else begin
            busReady_i = 1'b1;
        end
    end

    task automatic prime(input logic [1:0] be, input logic we,
                         input logic [31:0] a, input logic [31:0] d,
                         input int hb, input int hl);
        int n = nbytes(be);
        exp_q.delete();
        obs_a.delete();
        obs_d.delete();
        beats_done = 0;
        hold_beat = hb;
        hold_left = hl;
        if (!misaligned(be, a))
            for (int k = 0; k < n; k++)
                exp_q.push_back('{a + 32'(k), we, d[8 * k +: 8]});
    endtask

    task automatic issue(input logic [1:0] be, input logic sgn,
                         input logic we, input logic [31:0] a,
                         input logic [31:0] d, input int hb, input int hl);
        @(posedge clk);
        #1;
        byteEnable_i = be;
        byteExtend_i = sgn;
        writeEnable_i = we;
        addr_i = a;
        data_i = d;
        req_i = 1'b1;
        prime(be, we, a, d, hb, hl);
    endtask

    task automatic wait_done(input string nm, input int exp_stall,
                             input logic [31:0] exp_out,
                             input logic exp_fault);
        int cnt = 0;
        bit fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (!stall_o) fin = 1'b1;
            else cnt++;
            if (cnt > 200) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout got %0d expected done", nm, cnt);
                fin = 1'b1;
            end
        end
        chk({nm, "_stall"}, cnt, exp_stall);
        chk({nm, "_out"}, out_o, exp_out);
        chk({nm, "_fault"}, {31'd0, fault_o}, {31'd0, exp_fault});
        chk({nm, "_left"}, exp_q.size(), 0);
        out_model = exp_out;
        @(posedge clk);
        #1;
        req_i = 1'b0;
    endtask

    task automatic txn(input string nm, input logic [1:0] be,
                       input logic sgn, input logic we,
                       input logic [31:0] a, input logic [31:0] d,
                       input int hb, input int hl);
        int n = nbytes(be);
        bit mis = misaligned(be, a);
        int es;
        logic [31:0] eo;
        es = (n == 0) ? 0 : (mis ? 1 : n + 1 + hl);
        eo = (n > 0 && !mis && !we) ? load_val(be, sgn, a) : out_model;
        issue(be, sgn, we, a, d, hb, hl);
        wait_done(nm, es, eo, (n > 0) && mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] eo;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h80;
        mem[8'h04] = 8'h34;
        mem[8'h05] = 8'hF2;
        mem[8'hFE] = 8'h01;
        mem[8'hFF] = 8'h02;
        mem[8'h00] = 8'h03;
        mem[8'h01] = 8'h04;
        mem[8'h02] = 8'hA1;
        mem[8'h03] = 8'hB2;
        mem[8'h30] = 8'hFF;
        mem[8'h31] = 8'h7F;
        mem[8'h32] = 8'h00;
        mem[8'h33] = 8'h80;
        mem[8'h40] = 8'h11;
        mem[8'h41] = 8'h22;
        mem[8'h42] = 8'h33;
        mem[8'h43] = 8'h44;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out_o, 32'd0);
        chk("rst_valid", {31'd0, busValid_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        rst_i = 1'b0;

        txn("sb_load", 2'd1, 1'b1, 1'b0, 32'h10, 32'h0, -1, 0);
        chk("sb_load_lit", out_o, 32'hFFFFFF80);
        chk("sb_load_addr", obs_a[0], 32'h10);

        txn("w_store", 2'd3, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, -1, 0);
        chk("w_store_keep", out_o, 32'hFFFFFF80);
        chk("w_store_a3", obs_a[3], 32'h23);
        chk("w_store_d0", {24'd0, obs_d[0]}, 32'hDD);
        chk("w_store_d3", {24'd0, obs_d[3]}, 32'hAA);

        txn("uh_hold", 2'd2, 1'b0, 1'b0, 32'h04, 32'h0, 1, 3);
        chk("uh_hold_lit", out_o, 32'h0000F234);

        txn("w_wrap", 2'd3, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, -1, 0);
        chk("w_wrap_lit", out_o, 32'h04030201);
        chk("w_wrap_a0", obs_a[0], 32'hFFFFFFFE);
        chk("w_wrap_a1", obs_a[1], 32'hFFFFFFFF);
        chk("w_wrap_a2", obs_a[2], 32'h00000000);
        chk("w_wrap_a3", obs_a[3], 32'h00000001);

        txn("w_mis", 2'd3, 1'b0, 1'b0, 32'h02, 32'h0, -1, 0);
`ifdef MIPS_DATAPATH_MEMORY_BUS_MASTER_ALIGN_CHECK_EN
        chk("w_mis_keep", out_o, 32'h04030201);
        chk("w_mis_nobeat", obs_a.size(), 0);
`else
        chk("w_mis_lit", out_o, 32'hF234B2A1);
        chk("w_mis_a3", obs_a[3], 32'h05);
`endif

        txn("none", 2'd0, 1'b0, 1'b0, 32'h10, 32'h0, -1, 0);
        chk("none_nobeat", obs_a.size(), 0);

        txn("sh_pos", 2'd2, 1'b1, 1'b0, 32'h30, 32'h0, -1, 0);
        chk("sh_pos_lit", out_o, 32'h00007FFF);
        txn("sh_neg", 2'd2, 1'b1, 1'b0, 32'h32, 32'h0, 0, 2);
        chk("sh_neg_lit", out_o, 32'hFFFF8000);
        txn("ub_load", 2'd1, 1'b0, 1'b0, 32'h10, 32'h0, -1, 0);
        chk("ub_load_lit", out_o, 32'h00000080);
        txn("b_store", 2'd1, 1'b0, 1'b1, 32'h77, 32'h5A, 0, 1);
        chk("b_store_d", {24'd0, obs_d[0]}, 32'h5A);

        // Reset in the middle of a word load, request kept asserted
        issue(2'd3, 1'b0, 1'b0, 32'h40, 32'h0, -1, 0);
        for (int i = 0; i < 50 && beats_done < 2; i++) @(negedge clk);
        chk("rst_mid_beats", beats_done, 2);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, busValid_o}, 32'd0);
        chk("rst_mid_out", out_o, 32'd0);
        exp_q.delete();
        out_model = 32'd0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        prime(2'd3, 1'b0, 32'h40, 32'h0, -1, 0);
        eo = load_val(2'd3, 1'b0, 32'h40);
        wait_done("rst_fresh", 5, eo, 1'b0);
        chk("rst_fresh_lit", out_o, 32'h44332211);
        chk("rst_fresh_a0", obs_a[0], 32'h40);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_datapath_memory_bus_master.md
MIPS_DATAPATH_MEMORY_BUS_MASTER -- requirements
Module: mips_datapath_memory_bus_master

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of pipeline and bus address.
REQ-002 ctrl  input  Data_Control_Control_T bundle: Clock (rising edge) and Reset (asynchronous, active-high).
REQ-003 control  input  Mips_Control_Signal_Memory_Control_T: ByteEnable (None/Byte/Half/Word), ByteExtend (Unsigned/Signed), WriteEnable.
REQ-004 req  input  1: pipeline memory-stage request valid; held stable with addr/data/control while stall=1.
REQ-005 addr  input  ADDR_W: base byte address.
REQ-006 data  input  32: store data, byte k = bits 8k+7:8k.
REQ-007 out  output  32: registered load result, extended.
REQ-008 stall  output  1: pipeline hold.
REQ-009 fault  output  1: misalignment pulse (see Configuration).
REQ-010 busValid  output  1; busWrite  output  1; busAddr  output  ADDR_W; busWData  output  8: byte-bus request.
REQ-011 busReady  input  1; busRData  input  8: byte-bus response, sampled when busValid & busReady.

Function
REQ-012 Length N = 1/2/4 bytes for Byte/Half/Word; ByteEnable None or any undefined code starts no transaction.
REQ-013 FSM states IDLE, XFER, DONE; IDLE -> XFER on req & N!=0, latching addr, data, control, count=0.
REQ-014 stall = (IDLE & req & N!=0) | XFER; stall=0 in IDLE otherwise and in DONE.
REQ-015 XFER: busValid=1, busAddr=latched base+count (mod 2^ADDR_W), busWrite=latched WriteEnable, busWData=data byte[count].
REQ-016 Outputs in REQ-015 are held constant until busReady; busValid=0 in IDLE and DONE.
REQ-017 On XFER handshake: load captures busRData into lane[count]; count increments; count==N-1 at handshake -> DONE.
REQ-018 DONE -> IDLE unconditionally; req observed in DONE is ignored (same instruction still presented).
REQ-019 On load completion (XFER->DONE edge) out = lanes, zero-extended if Unsigned, else sign-extended from bit 8N-1; Word unextended.
REQ-020 Stores leave out unchanged; byte order little-endian (byte k at base+k).
REQ-021 Latency with busReady tied high: stall high N+1 cycles (IDLE request cycle plus N XFER cycles), DONE on cycle N+1 after request, out valid in DONE.
REQ-022 busReady stalls extend XFER indefinitely; no timeout.

Reset
REQ-023 Reset asserted: state IDLE, count 0, out 0, fault 0, lanes 0, busValid 0 immediately (asynchronous), including mid-XFER.
REQ-024 Transaction aborted by reset is not resumed; after deassertion a still-asserted req starts a fresh transaction.

Configuration
REQ-025 Macro MIPS_DATAPATH_MEMORY_BUS_MASTER_ALIGN_CHECK_EN.
REQ-026 Defined: Half with addr[0]=1 or Word with addr[1:0]!=0 goes IDLE -> DONE with no bus cycles, out unchanged, fault=1 for the DONE cycle only.
REQ-027 Undefined: fault tied 0; misaligned accesses proceed byte-wise per REQ-015.

Verification
REQ-028 Signed byte load addr=0x10, busRData=0x80, busReady=1 -> busAddr 0x10 one cycle, out=0xFFFFFF80 in DONE, stall 2 cycles.
REQ-029 Word store addr=0x20, data=0xAABBCCDD -> busWData DD,CC,BB,AA at 0x20..0x23, busWrite=1, out unchanged.
REQ-030 Unsigned half load addr=0x04, bytes 0x34,0xF2, busReady low 3 cycles before second byte -> busAddr/busWData held, out=0x0000F234.
REQ-031 Reset asserted mid-word load after 2 bytes -> busValid 0 same cycle, out=0, IDLE; req held -> new transaction from byte 0.
REQ-032 Word load addr=0xFFFFFFFE (ADDR_W=32) -> busAddr FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-033 ALIGN_CHECK_EN defined, Word load addr=0x02 -> no busValid, fault=1 one cycle, stall 1 cycle; undefined -> four bus reads 0x02..0x05.
